tage_ctr_update: RTL and testbench

Parametrised update/lookup engine for one TAGE tagged-table component. It holds the table's saturating prediction counters and useful counters. It serves a registered lookup port, and it applies update requests through a 2-stage read-modify-write pipeline with same-index forwarding. It also clears the table after reset and periodically ages the useful counters. It replaces the single-bit increment/decrement decision logic and sits between the predictor's update controller and each tagged table.

---
 rtl/tage_ctr_update.sv | 234 +++++++++++++++++++++++
 tb/tb_tage_ctr_update.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tage_ctr_update.sv
// tage_ctr_update
//
// Update/lookup engine for one TAGE tagged-table component. It holds the
// prediction counters (ctr) and useful counters (u) for DEPTH = 2^IDX_W
// entries.
//
// After reset, an INIT sweep writes ctr=WEAK_NT and u=0 into every entry.
//
// In RUN, updates flow through a 2-stage read-modify-write pipeline:
//   S1 registers the request and reads the entry.
//   S2 computes the new values and writes them.
// Same-index back-to-back updates compound via forwarding.
//
// Every AGE_PERIOD accepted updates, the engine stops accepting, drains the
// pipeline, and sweeps the table halving every useful counter (AGE).
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   upd_valid        update request present
//   upd_ready        update accepted on an edge where upd_valid && upd_ready
//   upd_idx          entry to update
//   upd_taken        resolved branch direction
//   upd_alloc        allocate entry: ctr=weak(taken), u=0
//   upd_u_inc        useful counter increment request
//   upd_u_dec        useful counter decrement request
//   lkp_idx          lookup index, sampled every edge
//   lkp_ctr, lkp_u   entry contents as of the sampling edge (1-cycle latency)
//   lkp_taken        MSB of lkp_ctr
//   init_done        initial clear complete

module tage_ctr_update #(
  parameter int CTR_W      = 3,
  parameter int U_W        = 2,
  parameter int IDX_W      = 10,
  parameter int AGE_PERIOD = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_alloc,
  input  logic             upd_u_inc,
  input  logic             upd_u_dec,
  input  logic [IDX_W-1:0] lkp_idx,
  output logic [CTR_W-1:0] lkp_ctr,
  output logic [U_W-1:0]   lkp_u,
  output logic             lkp_taken,
  output logic             init_done
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int AC_W  = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;

  localparam logic [CTR_W-1:0] WEAK_NT  = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] WEAK_T   = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0] CMAX     = '1;
  localparam logic [U_W-1:0]   UMAX     = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;
  localparam logic [AC_W-1:0]  AGE_LAST = AC_W'(AGE_PERIOD - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_AGE
  } state_e;

  // Table storage
  logic [CTR_W-1:0] ctr_mem [DEPTH];
  logic [U_W-1:0]   u_mem   [DEPTH];

  // Control state
  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [AC_W-1:0]  age_cnt_q;
  logic             age_pend_q;
  logic             age_start;

  // S1 pipeline register
  logic             s1_valid_q;
  logic [IDX_W-1:0] s1_idx_q;
  logic             s1_taken_q;
  logic             s1_alloc_q;
  logic             s1_inc_q;
  logic             s1_dec_q;
  logic [CTR_W-1:0] s1_ctr_q;
  logic [U_W-1:0]   s1_u_q;

  // S2 results and table write port
  logic [CTR_W-1:0] new_ctr;
  logic [U_W-1:0]   new_u;
  logic             wr_en;
  logic             wr_ctr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [CTR_W-1:0] wr_ctr;
  logic [U_W-1:0]   wr_u;

  logic             accept;
  logic             fwd_hit;

  logic [CTR_W-1:0] lkp_ctr_q;
  logic [U_W-1:0]   lkp_u_q;

  assign upd_ready = (state_q == S_RUN) && !age_pend_q;
  assign accept    = upd_valid && upd_ready;
  assign init_done = (state_q != S_INIT);
  assign lkp_ctr   = lkp_ctr_q;
  assign lkp_u     = lkp_u_q;
  assign lkp_taken = lkp_ctr_q[CTR_W-1];

  // The S2 write in this cycle lands on the same edge S1 reads the array.
  // Take the S2 result instead of the stale array contents.
  assign fwd_hit = s1_valid_q && (s1_idx_q == upd_idx);

  // S2: counter arithmetic
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned (which would infer a latch).
    new_ctr = s1_ctr_q;
    new_u   = s1_u_q;
    if (s1_alloc_q) begin
      new_ctr = s1_taken_q ? WEAK_T : WEAK_NT;
      new_u   = '0;
    end else begin
      if (s1_taken_q) begin
        if (s1_ctr_q != CMAX) new_ctr = s1_ctr_q + 1'b1;
      end else if (s1_ctr_q != '0) begin
        new_ctr = s1_ctr_q - 1'b1;
      end
      if (s1_inc_q && !s1_dec_q) begin
        if (s1_u_q != UMAX) new_u = s1_u_q + 1'b1;
      end else if (s1_dec_q && !s1_inc_q) begin
        if (s1_u_q != '0) new_u = s1_u_q - 1'b1;
      end
    end
  end

  // FSM next state and table write-port selection. Only one source writes in
  // any state: the INIT sweep, the S2 update, or the AGE sweep.
  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    age_start = 1'b0;
    wr_en     = 1'b0;
    wr_ctr_en = 1'b1;
    wr_idx    = sweep_q;
    wr_ctr    = WEAK_NT;
    wr_u      = '0;
    unique case (state_q)
      S_INIT: begin
        wr_en   = 1'b1;
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == LAST_IDX) state_d = S_RUN;
      end
      S_RUN: begin
        if (s1_valid_q) begin
          wr_en  = 1'b1;
          wr_idx = s1_idx_q;
          wr_ctr = new_ctr;
          wr_u   = new_u;
        end
        // Start aging only once the last accepted update has been written.
        if (age_pend_q && !s1_valid_q) begin
          state_d   = S_AGE;
          age_start = 1'b1;
        end
      end
      S_AGE: begin
        wr_en     = 1'b1;
        wr_ctr_en = 1'b0;
        wr_u      = u_mem[sweep_q] >> 1;
        sweep_d   = sweep_q + 1'b1;
        if (sweep_q == LAST_IDX) state_d = S_RUN;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Control registers and lookup output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      sweep_q    <= '0;
      age_cnt_q  <= '0;
      age_pend_q <= 1'b0;
      s1_valid_q <= 1'b0;
      lkp_ctr_q  <= '0;
      lkp_u_q    <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register
      // samples pre-edge values, regardless of statement order.
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      s1_valid_q <= accept;
      if (accept) begin
        if (age_cnt_q == AGE_LAST) begin
          age_cnt_q  <= '0;
          age_pend_q <= 1'b1;
        end else begin
          age_cnt_q <= age_cnt_q + 1'b1;
        end
      end else if (age_start) begin
        age_pend_q <= 1'b0;
      end
      // Read-before-write: a write committing on this edge is not visible.
      lkp_ctr_q <= ctr_mem[lkp_idx];
      lkp_u_q   <= u_mem[lkp_idx];
    end
  end

  // S1 payload; qualified by s1_valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_idx_q   <= upd_idx;
      s1_taken_q <= upd_taken;
      s1_alloc_q <= upd_alloc;
      s1_inc_q   <= upd_u_inc;
      s1_dec_q   <= upd_u_dec;
      s1_ctr_q   <= fwd_hit ? new_ctr : ctr_mem[upd_idx];
      s1_u_q     <= fwd_hit ? new_u   : u_mem[upd_idx];
    end
  end

  // NOTE: the table arrays are deliberately not reset; the INIT sweep clears
  // them, which keeps them mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_ctr_en) ctr_mem[wr_idx] <= wr_ctr;
      u_mem[wr_idx] <= wr_u;
    end
  end

endmodule

// File: tb/tb_tage_ctr_update.sv
// Testbench for tage_ctr_update. Two instances are used:
//   dut_a: default geometry (1024 entries, aging every 256 updates).
//   dut_b: small geometry (8 entries, aging every 4 updates).
// Shared stimulus signals drive both; each instance has its own upd_valid.
// Lookup expectations come from a behavioural table model. They are pushed to
// a scoreboard queue when the lookup is driven, then popped and compared once
// the DUT has produced the result.

module tb_tage_ctr_update;

  localparam int CTR_W   = 3;
  localparam int U_W     = 2;
  localparam int IDX_A   = 10;
  localparam int IDX_B   = 3;
  localparam int AGE_A   = 256;
  localparam int AGE_B   = 4;
  localparam int DEPTH_A = 1 << IDX_A;
  localparam int DEPTH_B = 1 << IDX_B;

  localparam int WNT  = 2 ** (CTR_W - 1) - 1;
  localparam int WT   = 2 ** (CTR_W - 1);
  localparam int CMAX = 2 ** CTR_W - 1;
  localparam int UMAX = 2 ** U_W - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic             upd_valid_a = 1'b0;
  logic             upd_valid_b = 1'b0;
  logic [IDX_A-1:0] upd_idx     = '0;
  logic [IDX_A-1:0] lkp_idx     = '0;
  logic             upd_taken   = 1'b0;
  logic             upd_alloc   = 1'b0;
  logic             upd_u_inc   = 1'b0;
  logic             upd_u_dec   = 1'b0;

  logic             upd_ready_a, init_done_a, lkp_taken_a;
  logic [CTR_W-1:0] lkp_ctr_a;
  logic [U_W-1:0]   lkp_u_a;
  logic             upd_ready_b, init_done_b, lkp_taken_b;
  logic [CTR_W-1:0] lkp_ctr_b;
  logic [U_W-1:0]   lkp_u_b;

  always #5 clk = ~clk;

  tage_ctr_update #(
    .CTR_W(CTR_W), .U_W(U_W), .IDX_W(IDX_A), .AGE_PERIOD(AGE_A)
  ) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .upd_valid (upd_valid_a),
    .upd_ready (upd_ready_a),
    .upd_idx   (upd_idx),
    .upd_taken (upd_taken),
    .upd_alloc (upd_alloc),
    .upd_u_inc (upd_u_inc),
    .upd_u_dec (upd_u_dec),
    .lkp_idx   (lkp_idx),
    .lkp_ctr   (lkp_ctr_a),
    .lkp_u     (lkp_u_a),
    .lkp_taken (lkp_taken_a),
    .init_done (init_done_a)
  );

  tage_ctr_update #(
    .CTR_W(CTR_W), .U_W(U_W), .IDX_W(IDX_B), .AGE_PERIOD(AGE_B)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .upd_valid (upd_valid_b),
    .upd_ready (upd_ready_b),
    .upd_idx   (upd_idx[IDX_B-1:0]),
    .upd_taken (upd_taken),
    .upd_alloc (upd_alloc),
    .upd_u_inc (upd_u_inc),
    .upd_u_dec (upd_u_dec),
    .lkp_idx   (lkp_idx[IDX_B-1:0]),
    .lkp_ctr   (lkp_ctr_b),
    .lkp_u     (lkp_u_b),
    .lkp_taken (lkp_taken_b),
    .init_done (init_done_b)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural table models
  int ma_ctr [DEPTH_A];
  int ma_u   [DEPTH_A];
  int mb_ctr [DEPTH_B];
  int mb_u   [DEPTH_B];

  typedef struct {
    bit    inst_b;
    int    ctr;
    int    u;
    string tag;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input bit b);
    if (b) begin
      for (int i = 0; i < DEPTH_B; i++) begin
        mb_ctr[i] = WNT;
        mb_u[i]   = 0;
      end
    end else begin
      for (int i = 0; i < DEPTH_A; i++) begin
        ma_ctr[i] = WNT;
        ma_u[i]   = 0;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".a_ready"}, 32'(upd_ready_a), 0);
    check({tag, ".a_init"},  32'(init_done_a), 0);
    check({tag, ".a_ctr"},   32'(lkp_ctr_a),   0);
    check({tag, ".a_u"},     32'(lkp_u_a),     0);
    check({tag, ".a_tkn"},   32'(lkp_taken_a), 0);
    check({tag, ".b_ready"}, 32'(upd_ready_b), 0);
    check({tag, ".b_init"},  32'(init_done_b), 0);
    check({tag, ".b_ctr"},   32'(lkp_ctr_b),   0);
    check({tag, ".b_u"},     32'(lkp_u_b),     0);
    check({tag, ".b_tkn"},   32'(lkp_taken_b), 0);
  endtask

  // Drive one update at a negedge; it is accepted on the following posedge.
  task automatic upd(input bit b, input int idx, input bit taken, input bit alloc,
                     input bit inc, input bit dec, input string tag);
    int c;
    int u;
    upd_idx   = IDX_A'(idx);
    upd_taken = taken;
    upd_alloc = alloc;
    upd_u_inc = inc;
    upd_u_dec = dec;
    if (b) upd_valid_b = 1'b1;
    else   upd_valid_a = 1'b1;
    check({tag, ".ready"}, 32'(b ? upd_ready_b : upd_ready_a), 1);
    @(negedge clk);
    upd_valid_a = 1'b0;
    upd_valid_b = 1'b0;
    c = b ? mb_ctr[idx] : ma_ctr[idx];
    u = b ? mb_u[idx]   : ma_u[idx];
    if (alloc) begin
      c = taken ? WT : WNT;
      u = 0;
    end else begin
      c = taken ? c + 1 : c - 1;
      if (c > CMAX) c = CMAX;
      if (c < 0)    c = 0;
      if (inc && !dec) u = u + 1;
      if (dec && !inc) u = u - 1;
      if (u > UMAX) u = UMAX;
      if (u < 0)    u = 0;
    end
    if (b) begin
      mb_ctr[idx] = c;
      mb_u[idx]   = u;
    end else begin
      ma_ctr[idx] = c;
      ma_u[idx]   = u;
    end
  endtask

  task automatic pop_cmp();
    exp_t e;
    e = sb.pop_front();
    check({e.tag, ".ctr"},   32'(e.inst_b ? lkp_ctr_b   : lkp_ctr_a), e.ctr);
    check({e.tag, ".u"},     32'(e.inst_b ? lkp_u_b     : lkp_u_a),   e.u);
    check({e.tag, ".taken"}, 32'(e.inst_b ? lkp_taken_b : lkp_taken_a),
          (e.ctr >= WT) ? 1 : 0);
  endtask

  task automatic lookup_exp(input bit b, input int idx, input int c, input int u,
                            input string tag);
    exp_t e;
    lkp_idx  = IDX_A'(idx);
    e.inst_b = b;
    e.ctr    = c;
    e.u      = u;
    e.tag    = tag;
    sb.push_back(e);
    @(negedge clk);
    pop_cmp();
  endtask

  task automatic lookup(input bit b, input int idx, input string tag);
    if (b) lookup_exp(b, idx, mb_ctr[idx], mb_u[idx], tag);
    else   lookup_exp(b, idx, ma_ctr[idx], ma_u[idx], tag);
  endtask

  initial begin
    int low;
    model_clear(0);
    model_clear(1);

    // Reset state
    #2 rst_n = 1'b0;
    #1 check_zero("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // INIT length: DEPTH edges after release
    repeat (DEPTH_B - 1) @(negedge clk);
    check("b.init_early", 32'(init_done_b), 0);
    @(negedge clk);
    check("b.init_done", 32'(init_done_b), 1);
    check("b.ready",     32'(upd_ready_b), 1);
    repeat (DEPTH_A - DEPTH_B - 1) @(negedge clk);
    check("a.init_early",  32'(init_done_a), 0);
    check("a.ready_early", 32'(upd_ready_a), 0);
    @(negedge clk);
    check("a.init_done", 32'(init_done_a), 1);
    check("a.ready",     32'(upd_ready_a), 1);

    // Cleared contents
    lookup(0, 0, "a.init0");
    lookup(0, 5, "a.init5");
    lookup(0, DEPTH_A - 1, "a.init_last");

    // Saturating increment, then saturating decrement
    for (int i = 0; i < 5; i++) begin
      upd(0, 5, 1'b1, 1'b0, 1'b0, 1'b0, "a.inc");
      @(negedge clk);
      lookup(0, 5, $sformatf("a.taken%0d", i));
    end
    for (int i = 0; i < 8; i++) begin
      upd(0, 5, 1'b0, 1'b0, 1'b0, 1'b0, "a.dec");
      @(negedge clk);
      lookup(0, 5, $sformatf("a.ntaken%0d", i));
    end

    // Back-to-back updates to one index compound through forwarding. One
    // edge after the last accept the final write is still committing, so
    // the lookup shows the value after two updates (3 -> 5).
    for (int i = 0; i < 3; i++) upd(0, 9, 1'b1, 1'b0, 1'b0, 1'b0, "a.fwd");
    lookup_exp(0, 9, 5, 0, "a.fwd_rbw");
    lookup(0, 9, "a.fwd6");

    // Allocation and useful-counter rules on idx 20
    for (int i = 0; i < 3; i++) upd(0, 20, 1'b0, 1'b0, 1'b1, 1'b0, "a.prep");
    @(negedge clk);
    lookup(0, 20, "a.prep20");
    upd(0, 20, 1'b1, 1'b1, 1'b1, 1'b0, "a.alloc");
    @(negedge clk);
    lookup(0, 20, "a.alloc20");
    upd(0, 20, 1'b1, 1'b0, 1'b1, 1'b1, "a.incdec");
    @(negedge clk);
    lookup(0, 20, "a.incdec20");
    for (int i = 0; i < 4; i++) upd(0, 20, 1'b0, 1'b0, 1'b1, 1'b0, "a.uinc");
    @(negedge clk);
    lookup(0, 20, "a.usat20");
    upd(0, 20, 1'b0, 1'b0, 1'b0, 1'b1, "a.udec");
    @(negedge clk);
    lookup(0, 20, "a.udec20");

    // Aging on dut_b: u=3 at idx 2, then the 4th accept triggers the stall
    for (int i = 0; i < 3; i++) upd(1, 2, 1'b1, 1'b0, 1'b1, 1'b0, "b.prep");
    upd(1, 2, 1'b0, 1'b0, 1'b0, 1'b0, "b.thresh");
    low = 0;
    while (upd_ready_b === 1'b0 && low < 40) begin
      low++;
      @(negedge clk);
    end
    check("b.stall_len", 32'(low), 2 + DEPTH_B);
    for (int i = 0; i < DEPTH_B; i++) mb_u[i] = mb_u[i] / 2;
    lookup(1, 2, "b.aged2");
    lookup(1, 0, "b.aged0");

    // Reset in the middle of an AGE sweep
    for (int i = 0; i < 4; i++) upd(1, 3, 1'b1, 1'b0, 1'b0, 1'b0, "b.c");
    repeat (4) @(negedge clk);
    check("b.mid_age_ready", 32'(upd_ready_b), 0);
    check("b.mid_age_init",  32'(init_done_b), 1);
    rst_n = 1'b0;
    #1 check_zero("rst2");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DEPTH_B - 1) @(negedge clk);
    check("b.reinit_early", 32'(init_done_b), 0);
    @(negedge clk);
    check("b.reinit_done",  32'(init_done_b), 1);
    check("b.reinit_ready", 32'(upd_ready_b), 1);
    model_clear(1);
    for (int i = 0; i < DEPTH_B; i++) lookup(1, i, $sformatf("b.clr%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
